// File: rtl/multsigned_mac_array.sv
// multsigned_mac_array: three-stage pipelined signed dot-product accumulator.
// S1 registers the per-lane products, S2 the adder-tree sum and last flag, and S3
// holds the running accumulator and the valid/ready output register.
// Optional build macro MULTSIGNED_MAC_SATURATE_EN: the accumulate add clamps at the
// ACC_SIZE signed limits instead of wrapping.
module multsigned_mac_array #(
    parameter int IN_SIZE_0  = 4,
    parameter int IN_SIZE_1  = 8,
    parameter int ARRAY_SIZE = 8,
    parameter int ACC_SIZE   = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [IN_SIZE_0-1:0]       in_0_i [0:ARRAY_SIZE-1],
    input  logic [IN_SIZE_1-1:0]       in_1_i [0:ARRAY_SIZE-1],
    input  logic                       signed_1_i,
    input  logic                       in_last_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic signed [ACC_SIZE-1:0] out_o
);

    localparam int PROD_SIZE = IN_SIZE_0 + IN_SIZE_1;
    localparam int SUM_SIZE  = PROD_SIZE + $clog2(ARRAY_SIZE);

    if (ACC_SIZE < SUM_SIZE) begin : g_bad_acc_size
        $error("ACC_SIZE must be at least SUM_SIZE");
    end
    if ((ARRAY_SIZE < 2) || ((ARRAY_SIZE & (ARRAY_SIZE - 1)) != 0)) begin : g_bad_array_size
        $error("ARRAY_SIZE must be a power of two and at least 2");
    end

    // Stage registers
    logic                        s1_valid_q;
    logic                        s1_last_q;
    logic signed [PROD_SIZE-1:0] s1_prod_q [ARRAY_SIZE];
    logic                        s2_valid_q;
    logic                        s2_last_q;
    logic signed [SUM_SIZE-1:0]  s2_sum_q;
    logic signed [ACC_SIZE-1:0]  acc_q;
    logic                        first_q;
    logic signed [ACC_SIZE-1:0]  out_q;
    logic                        out_valid_q;

    // Combinational next values
    logic signed [PROD_SIZE-1:0] prod_d [ARRAY_SIZE];
    logic signed [SUM_SIZE-1:0]  sum_d;
    logic signed [ACC_SIZE-1:0]  acc_base;
    logic signed [ACC_SIZE-1:0]  sum_ext;
    logic signed [ACC_SIZE-1:0]  acc_next;
    logic                        stall;

    assign stall       = out_valid_q && !out_ready_i;
    assign in_ready_o  = !stall;
    assign out_valid_o = out_valid_q;
    assign out_o       = out_q;

    // Lane products: both operands widened to PROD_SIZE; the true product always
    // fits in PROD_SIZE bits, so truncating the multiply is exact.
    always_comb begin
        for (int l = 0; l < ARRAY_SIZE; l++) begin
            logic signed [PROD_SIZE-1:0] op0;
            logic signed [PROD_SIZE-1:0] op1;
            op0 = PROD_SIZE'($signed(in_0_i[l]));
            if (signed_1_i) begin
                op1 = PROD_SIZE'($signed(in_1_i[l]));
            end else begin
                op1 = PROD_SIZE'(in_1_i[l]);
            end
            prod_d[l] = op0 * op1;
        end
    end

    // Adder tree over the registered products
    always_comb begin
        sum_d = '0;
        for (int l = 0; l < ARRAY_SIZE; l++) begin
            sum_d = sum_d + SUM_SIZE'(s1_prod_q[l]);
        end
    end

    assign acc_base = first_q ? '0 : acc_q;
    assign sum_ext  = ACC_SIZE'(s2_sum_q);

`ifdef MULTSIGNED_MAC_SATURATE_EN
    logic signed [ACC_SIZE:0] acc_wide;

    // Accumulate with one guard bit and clamp when the guard disagrees with the sign
    always_comb begin
        acc_wide = {acc_base[ACC_SIZE-1], acc_base} + {sum_ext[ACC_SIZE-1], sum_ext};
        if (acc_wide[ACC_SIZE] != acc_wide[ACC_SIZE-1]) begin
            acc_next = acc_wide[ACC_SIZE] ? {1'b1, {(ACC_SIZE-1){1'b0}}}
                                          : {1'b0, {(ACC_SIZE-1){1'b1}}};
        end else begin
            acc_next = acc_wide[ACC_SIZE-1:0];
        end
    end
`else
    // Plain two's-complement accumulate, wrapping at ACC_SIZE
    always_comb begin
        acc_next = acc_base + sum_ext;
    end
`endif

    // Pipeline advance: every stage moves together unless the output is stalled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            for (int l = 0; l < ARRAY_SIZE; l++) begin
                s1_prod_q[l] <= '0;
            end
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_sum_q    <= '0;
            acc_q       <= '0;
            first_q     <= 1'b1;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (!stall) begin
            s1_valid_q <= in_valid_i;
            if (in_valid_i) begin
                s1_last_q <= in_last_i;
                s1_prod_q <= prod_d;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_last_q <= s1_last_q;
                s2_sum_q  <= sum_d;
            end
            // Not stalled means any pending result is handshaking this cycle, so
            // the output stays valid only if a new group total lands now.
            out_valid_q <= s2_valid_q && s2_last_q;
            if (s2_valid_q) begin
                acc_q   <= acc_next;
                first_q <= s2_last_q;
                if (s2_last_q) begin
                    out_q <= acc_next;
                end
            end
        end
    end

endmodule
